// File: rtl/key_event_fifo.sv
// Keypad event buffer: synchronises scanner press/code into clk, queues codes in a
// small FIFO and raises one fixed-width interrupt pulse per queued entry.
module key_event_fifo #(
  parameter int DEPTH       = 8,
  parameter int CODE_W      = 4,
  parameter int INTR_CYCLES = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         press,
  input  logic [CODE_W-1:0]            key_code,
  input  logic                         rd_en,
  input  logic                         clr_ovf,
  output logic [7:0]                   rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         interrupt
);

  // state    | meaning
  // S_IDLE   | no pulse owed; leaves as soon as the FIFO holds data
  // S_PULSE  | interrupt high, timer runs down to terminal count
  // S_WAIT_ACK | pulse done; waits for one successful pop to re-arm

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMR_W = (INTR_CYCLES > 1) ? $clog2(INTR_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PULSE    = 2'd1,
    S_WAIT_ACK = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] press_sync;
  logic [SYNC_STAGES-1:0] sync_vld;
  logic [CODE_W-1:0]      code_sync [SYNC_STAGES];
  logic                   press_prev;
  logic                   push;
  logic [CODE_W-1:0]      push_code;

  logic [CODE_W-1:0]      mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   do_pop;
  logic                   do_push;
  logic                   drop;
  logic [CODE_W-1:0]      head;

  state_t                 state;
  state_t                 state_nxt;
  logic [TMR_W-1:0]       tmr;
  logic [TMR_W-1:0]       tmr_nxt;

  // sync_vld marks when the pipeline holds real post-reset samples; until then
  // prev is held at 1 so a press already held at reset release is not a new edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_sync <= '0;
      sync_vld   <= '0;
      press_prev <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) code_sync[i] <= '0;
    end else begin
      press_sync   <= {press_sync[SYNC_STAGES-2:0], press};
      sync_vld     <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
      press_prev   <= sync_vld[SYNC_STAGES-1] ? press_sync[SYNC_STAGES-1] : 1'b1;
      code_sync[0] <= key_code;
      for (int i = 1; i < SYNC_STAGES; i++) code_sync[i] <= code_sync[i-1];
    end
  end

  assign push      = sync_vld[SYNC_STAGES-1] & press_sync[SYNC_STAGES-1] & ~press_prev;
  assign push_code = code_sync[SYNC_STAGES-1];

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = rd_en & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign head    = empty ? '0 : mem[rd_ptr];
  assign rd_data = {overflow, empty, 6'b000000} | 8'(head);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tmr       <= '0;
      interrupt <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmr       <= tmr_nxt;
      interrupt <= (state_nxt == S_PULSE);
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_nxt = S_PULSE;
          tmr_nxt   = TMR_W'(INTR_CYCLES - 1);
        end
      end
      S_PULSE: begin
        if (tmr == '0) state_nxt = S_WAIT_ACK;
        else           tmr_nxt   = tmr - TMR_W'(1);
      end
      S_WAIT_ACK: begin
        if (do_pop) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo: hand-computed expectations for capture latency,
// ordering, overflow, full-wrap push/pop, empty reads and reset mid-pulse.
module tb_key_event_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       press;
  logic [3:0] key_code;
  logic       rd_en;
  logic       clr_ovf;
  logic [7:0] rd_data;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       interrupt;

  int checks = 0;
  int errors = 0;
  int int_hi = 0;
  int int_rise = 0;
  logic int_last = 1'b0;
  int snap_hi;
  int snap_rise;

  key_event_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .press     (press),
    .key_code  (key_code),
    .rd_en     (rd_en),
    .clr_ovf   (clr_ovf),
    .rd_data   (rd_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (interrupt) int_hi = int_hi + 1;
    if (interrupt && !int_last) int_rise = int_rise + 1;
    int_last = interrupt;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; press = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0; key_code = 4'h0;
    cycle(2);
    rst = 1'b0;
    cycle(5);
  endtask

  task automatic press_key(input logic [3:0] code);
    key_code = code; press = 1'b1;
    cycle(3);
    press = 1'b0;
    cycle(3);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    cycle(1);
    rd_en = 1'b0;
  endtask

  logic [7:0] drain_exp [8];

  initial begin
    rst = 1'b1; press = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0; key_code = 4'h0;
    drain_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09};

    // 1: reset state, single push with latency and one 3-cycle pulse
    do_reset();
    chk("rst_count", count, 4'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_int", interrupt, 1'b0);
    chk("rst_rd_data", rd_data, 8'h40);
    snap_hi = int_hi; snap_rise = int_rise;
    key_code = 4'h5; press = 1'b1;
    cycle(2);
    chk("lat_count_k1", count, 4'd0);
    cycle(1);
    chk("lat_count_k2", count, 4'd1);
    chk("lat_int_k2", interrupt, 1'b0);
    cycle(1);
    chk("lat_int_k3", interrupt, 1'b1);
    cycle(6);
    press = 1'b0;
    cycle(3);
    chk("t1_count", count, 4'd1);
    chk("t1_rd_data", rd_data, 8'h05);
    chk("t1_int_cycles", int_hi - snap_hi, 3);
    chk("t1_int_pulses", int_rise - snap_rise, 1);
    pop();
    cycle(3);
    chk("t1_drained", rd_data, 8'h40);

    // 2: ordering and one pulse per entry, re-armed by pops
    snap_rise = int_rise;
    press_key(4'h1);
    press_key(4'h2);
    press_key(4'h3);
    chk("t2_count", count, 4'd3);
    chk("t2_int_wait_ack", interrupt, 1'b0);
    chk("t2_rd0", rd_data, 8'h01);
    pop(); cycle(7);
    chk("t2_rd1", rd_data, 8'h02);
    pop(); cycle(7);
    chk("t2_rd2", rd_data, 8'h03);
    pop(); cycle(7);
    chk("t2_rd_empty", rd_data, 8'h40);
    chk("t2_pulses", int_rise - snap_rise, 3);

    // 3: overfill, sticky overflow, clear
    for (int i = 0; i < 9; i++) press_key(4'(i));
    chk("t3_full", full, 1'b1);
    chk("t3_count", count, 4'd8);
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_rd_data", rd_data, 8'h80);
    clr_ovf = 1'b1; cycle(1); clr_ovf = 1'b0;
    chk("t3_ovf_clr", overflow, 1'b0);
    chk("t3_rd_data_clr", rd_data, 8'h00);

    // 4: push and pop in the same cycle while full, then drain across the wrap
    key_code = 4'h9; press = 1'b1;
    cycle(2);
    rd_en = 1'b1;
    cycle(1);
    rd_en = 1'b0;
    chk("t4_count", count, 4'd8);
    chk("t4_ovf", overflow, 1'b0);
    chk("t4_full", full, 1'b1);
    press = 1'b0;
    cycle(3);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_drain%0d", i), rd_data, drain_exp[i]);
      pop();
    end
    chk("t4_rd_empty", rd_data, 8'h40);
    chk("t4_count_empty", count, 4'd0);

    // 5: read strobe on empty FIFO
    pop();
    cycle(1);
    chk("t5_count", count, 4'd0);
    chk("t5_rd_data", rd_data, 8'h40);
    chk("t5_full", full, 1'b0);

    // 6: reset mid-pulse with 3 entries, press held across release
    do_reset();
    press_key(4'hA);
    press_key(4'hB);
    press_key(4'hC);
    key_code = 4'hD; press = 1'b1;
    cycle(2);
    rd_en = 1'b1;
    cycle(1);
    rd_en = 1'b0;
    chk("t6_count", count, 4'd3);
    chk("t6_head", rd_data, 8'h0B);
    cycle(1);
    chk("t6_int_pulse", interrupt, 1'b1);
    rst = 1'b1;
    cycle(1);
    chk("t6_rst_int", interrupt, 1'b0);
    chk("t6_rst_empty", empty, 1'b1);
    chk("t6_rst_count", count, 4'd0);
    chk("t6_rst_rd_data", rd_data, 8'h40);
    rst = 1'b0;
    cycle(8);
    chk("t6_held_count", count, 4'd0);
    chk("t6_held_int", interrupt, 1'b0);
    press = 1'b0;
    cycle(3);
    press_key(4'h6);
    chk("t6_after_count", count, 4'd1);
    chk("t6_after_rd", rd_data, 8'h06);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
